periph_bus_arbiter: RTL and testbench
=====================================

Name: periph_bus_arbiter

Overview:
- Two-master arbiter and sequencer in front of the memory-mapped peripheral register block.
- Master 0 is the CPU data port; master 1 is the debug/OCD port. Each master uses a single Wishbone-classic request channel (hold STB until ACK).
- The block grants one master at a time and converts the request into the peripheral's split RD/WR ports with single-cycle strobes, so side-effecting registers fire exactly once (UART TX start, RX FIFO pop).
- It returns data and ACK to the owning master, with a bus-timeout error path.

Parameters:
- ADDR_BITS, default `MM_REG_ADDR_BITS: register address width.
- XLEN, default 32: data width. XLEN/8 byte selects.
- TIMEOUT_CYCLES, default 15: WAIT cycles without ACK before an error response. Must be ≥1.
- ROUND_ROBIN, default 1: 1 = round-robin arbitration; 0 = fixed priority, m0 always wins.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- m0_stb_i  in  1  master 0 request, held until m0_ack_o
- m0_we_i  in  1  1 = write, 0 = read
- m0_sel_i  in  XLEN/8  byte selects
- m0_adr_i  in  ADDR_BITS  register address
- m0_dat_i  in  XLEN  write data
- m0_dat_o  out  XLEN  read data, valid with m0_ack_o
- m0_ack_o  out  1  one-cycle completion
- m0_err_o  out  1  timeout flag, valid with m0_ack_o
- m1_*  same set and widths as m0_*, for master 1
- WB_RD_STB_O  out  1  peripheral read strobe
- WB_RD_ADR_O  out  ADDR_BITS  read address
- WB_RD_DAT_I  in  XLEN  peripheral read data
- WB_RD_ACK_I  in  1  peripheral read ack
- WB_WR_STB_O  out  1  peripheral write strobe
- WB_WR_WE_O  out  1  peripheral write enable
- WB_WR_SEL_O  out  XLEN/8  byte selects
- WB_WR_ADR_O  out  ADDR_BITS  write address
- WB_WR_DAT_O  out  XLEN  write data
- WB_WR_ACK_I  in  1  peripheral write ack
- busy  out  1  high in any state except IDLE
- owner  out  1  master index of the current/last grant

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; priority pointer favours m0; timeout counter 0; owner 0.
- An in-flight transaction is dropped on reset, with no ACK to its master.
- States IDLE → ISSUE → WAIT → RESP → IDLE. All outputs are registered.
- IDLE:
  - If any stb is high, select a master and latch its we/sel/adr/dat into the downstream address/data/sel registers, then go to ISSUE.
  - If both stb are high and ROUND_ROBIN=1, the pointer's master wins. After every grant the pointer moves to the other master.
  - If ROUND_ROBIN=0, m0 wins ties.
  - A single requester always wins, regardless of the pointer.
- ISSUE, exactly one cycle:
  - Write: WB_WR_STB_O=WB_WR_WE_O=1.
  - Read: WB_RD_STB_O=1.
  - Then go to WAIT.
- Strobe/address hold: strobes are never high for more than one cycle per transaction. Addresses, data and sel hold their latched values until the next grant.
- WAIT:
  - Only the ACK matching the op type counts: WB_WR_ACK_I for writes, WB_RD_ACK_I for reads. When it is seen, capture WB_RD_DAT_I (reads; writes return 0) and go to RESP with err=0.
  - The counter increments each WAIT cycle without that ACK. After TIMEOUT_CYCLES such cycles, go to RESP with err=1 and data 0.
  - Non-matching or stray ACKs are ignored in every state.
- RESP, one cycle: the owner's mX_ack_o=1, mX_dat_o=captured data, mX_err_o=err. The other master's outputs stay 0. Return to IDLE; the counter clears.
- Latency:
  - With the peripheral ACK registered one cycle after the strobe: stb seen in cycle 0 → ISSUE in cycle 1 → ACK seen in cycle 2 → master ack in cycle 3.
  - The minimum back-to-back issue interval is 4 cycles.
- Master handshake:
  - The master drops stb the cycle after ack, so IDLE does not re-grant the same request.
  - Changes to a non-granted master's inputs never affect the in-flight transaction.
  - A master that drops stb before its ack still completes the transaction; the ack is still pulsed.
- mX_dat_o/mX_err_o are 0 whenever mX_ack_o is 0.

Test Plan:
- m0 writes 0x41 to the UART TX address, sel=4'b0001. Required: WB_WR_WE_O high for exactly 1 cycle (cycle 1) with WB_WR_DAT_O=0x41; m0_ack_o in cycle 3, m0_err_o=0.
- m1 reads with WB_RD_DAT_I=0x8000_0000 returned with the ACK. Required: m1_dat_o=0x8000_0000 with m1_ack_o in cycle 3; m0 outputs stay 0.
- Both stb held high for 4 transactions, ROUND_ROBIN=1. Required grant order m0, m1, m0, m1; owner matches; issues spaced 4 cycles apart.
- Repeat the previous scenario with ROUND_ROBIN=0. Required: m0 granted all 4 times while it keeps requesting; m1 granted once m0 idles.
- Peripheral never ACKs, TIMEOUT_CYCLES=15. Required: ack with err=1 and dat=0 in cycle 17; next request proceeds normally.
- reset asserted in WAIT. Required: all outputs 0 immediately, no ack to the owner; after release m0 has priority and a fresh request completes in 3 cycles.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter in front of the peripheral register block: grants one
// Wishbone-classic master at a time and issues single-cycle RD/WR strobes.
`ifndef MM_REG_ADDR_BITS
`define MM_REG_ADDR_BITS 8
`endif

module periph_bus_arbiter #(
    parameter int ADDR_BITS      = `MM_REG_ADDR_BITS,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int ROUND_ROBIN    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m0_stb_i,
    input  logic                 m0_we_i,
    input  logic [XLEN/8-1:0]    m0_sel_i,
    input  logic [ADDR_BITS-1:0] m0_adr_i,
    input  logic [XLEN-1:0]      m0_dat_i,
    output logic [XLEN-1:0]      m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,
    input  logic                 m1_stb_i,
    input  logic                 m1_we_i,
    input  logic [XLEN/8-1:0]    m1_sel_i,
    input  logic [ADDR_BITS-1:0] m1_adr_i,
    input  logic [XLEN-1:0]      m1_dat_i,
    output logic [XLEN-1:0]      m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,
    output logic                 WB_RD_STB_O,
    output logic [ADDR_BITS-1:0] WB_RD_ADR_O,
    input  logic [XLEN-1:0]      WB_RD_DAT_I,
    input  logic                 WB_RD_ACK_I,
    output logic                 WB_WR_STB_O,
    output logic                 WB_WR_WE_O,
    output logic [XLEN/8-1:0]    WB_WR_SEL_O,
    output logic [ADDR_BITS-1:0] WB_WR_ADR_O,
    output logic [XLEN-1:0]      WB_WR_DAT_O,
    input  logic                 WB_WR_ACK_I,
    output logic                 busy,
    output logic                 owner
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]           state_r;
    logic                 we_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 rr_ptr_r;

    logic                 grant_s;
    logic                 sel_we_s;
    logic [XLEN/8-1:0]    sel_sel_s;
    logic [ADDR_BITS-1:0] sel_adr_s;
    logic [XLEN-1:0]      sel_dat_s;
    logic                 match_ack_s;
    logic                 timeout_s;
    logic [XLEN-1:0]      resp_dat_s;
    logic                 resp_err_s;

    // Arbitration: a lone requester always wins; ties go to the pointer or to m0.
    always_comb begin
        grant_s = 1'b0;
        if (m0_stb_i && m1_stb_i) begin
            if (ROUND_ROBIN != 0) begin
                grant_s = rr_ptr_r;
            end else begin
                grant_s = 1'b0;
            end
        end else if (m1_stb_i) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Request fields of the master that wins this cycle.
    always_comb begin
        sel_we_s  = m0_we_i;
        sel_sel_s = m0_sel_i;
        sel_adr_s = m0_adr_i;
        sel_dat_s = m0_dat_i;
        if (grant_s) begin
            sel_we_s  = m1_we_i;
            sel_sel_s = m1_sel_i;
            sel_adr_s = m1_adr_i;
            sel_dat_s = m1_dat_i;
        end else begin
            sel_we_s  = m0_we_i;
            sel_sel_s = m0_sel_i;
            sel_adr_s = m0_adr_i;
            sel_dat_s = m0_dat_i;
        end
    end

    // Only the ack of the op type in flight counts; a timeout returns zero data.
    always_comb begin
        match_ack_s = we_r ? WB_WR_ACK_I : WB_RD_ACK_I;
        timeout_s   = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
        resp_err_s  = ~match_ack_s;
        if (match_ack_s && !we_r) begin
            resp_dat_s = WB_RD_DAT_I;
        end else begin
            resp_dat_s = {XLEN{1'b0}};
        end
    end

    // Sequencer and registered outputs; strobes and acks default low every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            we_r        <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            rr_ptr_r    <= 1'b0;
            m0_dat_o    <= {XLEN{1'b0}};
            m0_ack_o    <= 1'b0;
            m0_err_o    <= 1'b0;
            m1_dat_o    <= {XLEN{1'b0}};
            m1_ack_o    <= 1'b0;
            m1_err_o    <= 1'b0;
            WB_RD_STB_O <= 1'b0;
            WB_RD_ADR_O <= {ADDR_BITS{1'b0}};
            WB_WR_STB_O <= 1'b0;
            WB_WR_WE_O  <= 1'b0;
            WB_WR_SEL_O <= {(XLEN/8){1'b0}};
            WB_WR_ADR_O <= {ADDR_BITS{1'b0}};
            WB_WR_DAT_O <= {XLEN{1'b0}};
            busy        <= 1'b0;
            owner       <= 1'b0;
        end else begin
            WB_RD_STB_O <= 1'b0;
            WB_WR_STB_O <= 1'b0;
            WB_WR_WE_O  <= 1'b0;
            m0_dat_o    <= {XLEN{1'b0}};
            m0_ack_o    <= 1'b0;
            m0_err_o    <= 1'b0;
            m1_dat_o    <= {XLEN{1'b0}};
            m1_ack_o    <= 1'b0;
            m1_err_o    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (m0_stb_i || m1_stb_i) begin
                        owner       <= grant_s;
                        rr_ptr_r    <= ~grant_s;
                        we_r        <= sel_we_s;
                        WB_RD_ADR_O <= sel_adr_s;
                        WB_WR_ADR_O <= sel_adr_s;
                        WB_WR_SEL_O <= sel_sel_s;
                        WB_WR_DAT_O <= sel_dat_s;
                        WB_RD_STB_O <= ~sel_we_s;
                        WB_WR_STB_O <= sel_we_s;
                        WB_WR_WE_O  <= sel_we_s;
                        busy        <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end else begin
                        busy        <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (match_ack_s || timeout_s) begin
                        if (owner) begin
                            m1_ack_o <= 1'b1;
                            m1_dat_o <= resp_dat_s;
                            m1_err_o <= resp_err_s;
                        end else begin
                            m0_ack_o <= 1'b1;
                            m0_dat_o <= resp_dat_s;
                            m0_err_o <= resp_err_s;
                        end
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench: dut_a is round-robin, dut_b fixed-priority; both share master stimulus.
module tb_periph_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_stb, m0_we, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [7:0]  m0_adr, m1_adr;
    logic [31:0] m0_dat, m1_dat;
    logic [31:0] rd_dat;
    logic        ack_en;

    logic [31:0] a_m0_dat, a_m1_dat, a_wr_dat, b_m0_dat, b_m1_dat, b_wr_dat;
    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
    logic        a_rd_stb, a_wr_stb, a_wr_we, a_busy, a_owner, a_rd_ack, a_wr_ack;
    logic        b_rd_stb, b_wr_stb, b_wr_we, b_busy, b_owner, b_rd_ack, b_wr_ack;
    logic [7:0]  a_rd_adr, a_wr_adr, b_rd_adr, b_wr_adr;
    logic [3:0]  a_wr_sel, b_wr_sel;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    periph_bus_arbiter #(.ADDR_BITS(8), .XLEN(32), .TIMEOUT_CYCLES(15), .ROUND_ROBIN(1)) dut_a (
        .clk(clk), .reset(reset),
        .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
        .m0_dat_o(a_m0_dat), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
        .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
        .m1_dat_o(a_m1_dat), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
        .WB_RD_STB_O(a_rd_stb), .WB_RD_ADR_O(a_rd_adr), .WB_RD_DAT_I(rd_dat), .WB_RD_ACK_I(a_rd_ack),
        .WB_WR_STB_O(a_wr_stb), .WB_WR_WE_O(a_wr_we), .WB_WR_SEL_O(a_wr_sel), .WB_WR_ADR_O(a_wr_adr),
        .WB_WR_DAT_O(a_wr_dat), .WB_WR_ACK_I(a_wr_ack), .busy(a_busy), .owner(a_owner)
    );

    periph_bus_arbiter #(.ADDR_BITS(8), .XLEN(32), .TIMEOUT_CYCLES(15), .ROUND_ROBIN(0)) dut_b (
        .clk(clk), .reset(reset),
        .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
        .m0_dat_o(b_m0_dat), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
        .m1_dat_o(b_m1_dat), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .WB_RD_STB_O(b_rd_stb), .WB_RD_ADR_O(b_rd_adr), .WB_RD_DAT_I(rd_dat), .WB_RD_ACK_I(b_rd_ack),
        .WB_WR_STB_O(b_wr_stb), .WB_WR_WE_O(b_wr_we), .WB_WR_SEL_O(b_wr_sel), .WB_WR_ADR_O(b_wr_adr),
        .WB_WR_DAT_O(b_wr_dat), .WB_WR_ACK_I(b_wr_ack), .busy(b_busy), .owner(b_owner)
    );

    // Peripheral model: acks one cycle after each strobe while ack_en is set.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rd_ack <= 1'b0;
            a_wr_ack <= 1'b0;
            b_rd_ack <= 1'b0;
            b_wr_ack <= 1'b0;
        end else begin
            a_rd_ack <= a_rd_stb & ack_en;
            a_wr_ack <= a_wr_stb & ack_en;
            b_rd_ack <= b_rd_stb & ack_en;
            b_wr_ack <= b_wr_stb & ack_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        ack_en = 1'b1;
        rd_dat = 32'h8000_0000;
        m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'h0; m0_adr = 8'h00; m0_dat = 32'h0;
        m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0; m1_adr = 8'h00; m1_dat = 32'h0;
        #1;
        chk("rst_busy", a_busy, 32'd0);
        chk("rst_owner", a_owner, 32'd0);
        chk("rst_m0_ack", a_m0_ack, 32'd0);
        chk("rst_wr_stb", a_wr_stb, 32'd0);
        chk("rst_rd_adr", a_rd_adr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // m0 writes 0x41 to UART TX
        m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'b0001; m0_adr = 8'h10; m0_dat = 32'h41;
        tick();
        chk("t1_wr_stb", a_wr_stb, 32'd1);
        chk("t1_wr_we", a_wr_we, 32'd1);
        chk("t1_wr_dat", a_wr_dat, 32'h41);
        chk("t1_wr_sel", a_wr_sel, 32'h1);
        chk("t1_wr_adr", a_wr_adr, 32'h10);
        chk("t1_rd_stb", a_rd_stb, 32'd0);
        chk("t1_busy", a_busy, 32'd1);
        tick();
        chk("t1_we_c2", a_wr_we, 32'd0);
        chk("t1_ack_c2", a_m0_ack, 32'd0);
        tick();
        chk("t1_ack", a_m0_ack, 32'd1);
        chk("t1_err", a_m0_err, 32'd0);
        chk("t1_m1_ack", a_m1_ack, 32'd0);
        chk("t1_b_ack", b_m0_ack, 32'd1);
        m0_stb = 1'b0;
        tick();
        chk("t1_ack_c4", a_m0_ack, 32'd0);
        chk("t1_busy_c4", a_busy, 32'd0);
        chk("t1_dat_hold", a_wr_dat, 32'h41);

        // m1 read, stb dropped early
        m1_stb = 1'b1; m1_we = 1'b0; m1_sel = 4'hF; m1_adr = 8'h20;
        tick();
        chk("t2_rd_stb", a_rd_stb, 32'd1);
        chk("t2_rd_adr", a_rd_adr, 32'h20);
        chk("t2_owner", a_owner, 32'd1);
        chk("t2_wr_stb", a_wr_stb, 32'd0);
        m1_stb = 1'b0;
        tick();
        chk("t2_rd_stb_c2", a_rd_stb, 32'd0);
        tick();
        chk("t2_m1_ack", a_m1_ack, 32'd1);
        chk("t2_m1_dat", a_m1_dat, 32'h8000_0000);
        chk("t2_m1_err", a_m1_err, 32'd0);
        chk("t2_m0_ack", a_m0_ack, 32'd0);
        chk("t2_m0_dat", a_m0_dat, 32'd0);
        tick();
        chk("t2_m1_ack_c4", a_m1_ack, 32'd0);
        chk("t2_m1_dat_c4", a_m1_dat, 32'd0);

        // both requesting continuously: a alternates, b stays on m0
        m0_stb = 1'b1; m0_we = 1'b1; m0_dat = 32'h55; m0_adr = 8'h14;
        m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 8'h24;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_a_owner", a_owner, 32'(k % 2));
            chk("t3_b_owner", b_owner, 32'd0);
            chk("t3_a_stb", (k % 2 == 1) ? a_rd_stb : a_wr_stb, 32'd1);
            chk("t3_b_stb", b_wr_stb, 32'd1);
            tick();
            tick();
            chk("t3_a_ack", (k % 2 == 1) ? a_m1_ack : a_m0_ack, 32'd1);
            chk("t3_a_other", (k % 2 == 1) ? a_m0_ack : a_m1_ack, 32'd0);
            chk("t3_b_ack", b_m0_ack, 32'd1);
            chk("t3_b_m1_ack", b_m1_ack, 32'd0);
            if (k == 3) m0_stb = 1'b0;
            tick();
            chk("t3_gap", a_rd_stb | a_wr_stb, 32'd0);
        end
        tick();
        chk("t4_b_owner", b_owner, 32'd1);
        chk("t4_b_rd_stb", b_rd_stb, 32'd1);
        tick();
        tick();
        chk("t4_b_m1_ack", b_m1_ack, 32'd1);
        chk("t4_b_m1_dat", b_m1_dat, 32'h8000_0000);
        chk("t4_b_m0_ack", b_m0_ack, 32'd0);
        m1_stb = 1'b0;
        tick();

        // timeout: peripheral silent
        ack_en = 1'b0;
        m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 8'h30;
        tick();
        repeat (15) tick();
        chk("t5_ack_c16", a_m0_ack, 32'd0);
        chk("t5_busy_c16", a_busy, 32'd1);
        tick();
        chk("t5_ack", a_m0_ack, 32'd1);
        chk("t5_err", a_m0_err, 32'd1);
        chk("t5_dat", a_m0_dat, 32'd0);
        m0_stb = 1'b0;
        ack_en = 1'b1;
        tick();
        chk("t5_err_c18", a_m0_err, 32'd0);
        chk("t5_busy_c18", a_busy, 32'd0);
        m1_stb = 1'b1; m1_we = 1'b1; m1_dat = 32'h77;
        tick();
        chk("t5_next_stb", a_wr_stb, 32'd1);
        chk("t5_next_dat", a_wr_dat, 32'h77);
        tick();
        tick();
        chk("t5_next_ack", a_m1_ack, 32'd1);
        chk("t5_next_err", a_m1_err, 32'd0);
        m1_stb = 1'b0;
        tick();

        // reset while waiting on a silent peripheral
        ack_en = 1'b0;
        m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 8'h40;
        tick();
        chk("t6_owner", a_owner, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", a_busy, 32'd0);
        chk("t6_rst_adr", a_rd_adr, 32'd0);
        chk("t6_rst_ack", a_m0_ack, 32'd0);
        m0_stb = 1'b0;
        tick();
        tick();
        chk("t6_no_ack", a_m0_ack, 32'd0);
        reset = 1'b0;
        ack_en = 1'b1;
        m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 8'h44;
        m1_stb = 1'b1; m1_we = 1'b1;
        tick();
        chk("t6_prio_owner", a_owner, 32'd0);
        chk("t6_prio_stb", a_rd_stb, 32'd1);
        tick();
        tick();
        chk("t6_fresh_ack", a_m0_ack, 32'd1);
        chk("t6_fresh_dat", a_m0_dat, 32'h8000_0000);
        m0_stb = 1'b0;
        m1_stb = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
